// File: rtl/univ_shift_reg_n.sv
// univ_shift_reg_n
//   Parametrised universal shift register. Supports hold, shift right,
//   shift left and parallel load as single-step operations, plus a burst
//   shift of a programmable number of positions with a busy/done handshake.
//
//   Optional build macro: UNIV_SHIFT_ROTATE_EN
//     Adds the rot input. When rot=1 at a shift edge, the bit shifted out
//     re-enters at the opposite end and sir/sil are ignored.
//
//   Ports
//     clk    in   system clock, rising edge
//     rst    in   synchronous active-high reset
//     en     in   single-step enable
//     mode   in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//     I      in   parallel load data [WIDTH]
//     sir    in   serial input for right shift (enters MSB)
//     sil    in   serial input for left shift (enters LSB)
//     start  in   burst request; direction from mode, count from amt
//     amt    in   burst shift count [CNT_W]
//     rot    in   rotate instead of serial fill (UNIV_SHIFT_ROTATE_EN only)
//     A      out  register contents
//     so_r   out  A[0]
//     so_l   out  A[WIDTH-1]
//     busy   out  burst in progress
//     done   out  one-cycle pulse when a burst completes
//
//   state    | meaning
//   ST_IDLE  | single-step operations; bursts may be accepted
//   ST_BURST | shifting once per edge until the counter runs out
module univ_shift_reg_n #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             sir,
  input  logic             sil,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] A,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic             rot_w;
  logic             fill_r, fill_l;
  logic [WIDTH-1:0] shr_w, shl_w;
  logic             burst_req;

`ifdef UNIV_SHIFT_ROTATE_EN
  assign rot_w = rot;
`else
  assign rot_w = 1'b0;
`endif

  // Bit entering the vacated end: the outgoing bit when rotating,
  // otherwise the serial input for that direction.
  assign fill_r = rot_w ? a_q[0]       : sir;
  assign fill_l = rot_w ? a_q[WIDTH-1] : sil;
  assign shr_w  = {fill_r, a_q[WIDTH-1:1]};
  assign shl_w  = {a_q[WIDTH-2:0], fill_l};

  // Only the two shift modes can start a burst; hold/load fall through
  // to a normal single-step edge.
  assign burst_req = start && (mode == 2'b01 || mode == 2'b10);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    case (state_q)
      ST_BURST: begin
        a_d   = (dir_q == DIR_LEFT) ? shl_w : shr_w;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (burst_req) begin
          dir_d = (mode == 2'b10) ? DIR_LEFT : DIR_RIGHT;
          cnt_d = amt;
          // A zero-length burst completes immediately without shifting.
          if (amt != '0) state_d = ST_BURST;
          else           done_d  = 1'b1;
        end else if (en) begin
          case (mode)
            2'b01:   a_d = shr_w;
            2'b10:   a_d = shl_w;
            2'b11:   a_d = I;
            default: a_d = a_q;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign A    = a_q;
  assign so_r = a_q[0];
  assign so_l = a_q[WIDTH-1];
  assign busy = (state_q == ST_BURST);
  assign done = done_q;

endmodule

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
- Parametrised universal shift register and successor to the fixed 4-bit parallel-load register.
- Supports hold, shift right, shift left and parallel load, plus a multi-cycle burst shift of a programmable number of positions with a busy/done handshake.
- Used as the datapath storage and serial-conversion element in later chapter designs (serial adders, multipliers).

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of the burst shift-amount field and internal counter. Localparam derived from WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  single-step operation enable.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- I  input  WIDTH  parallel load data.
- sir  input  1  serial input for right shift; enters the MSB.
- sil  input  1  serial input for left shift; enters the LSB.
- start  input  1  burst shift request. Direction comes from mode; amount comes from amt.
- amt  input  CNT_W  burst shift count.
- A  output  WIDTH  register contents (registered).
- so_r  output  1  A[0], combinational from A.
- so_l  output  1  A[WIDTH-1], combinational from A.
- busy  output  1  burst in progress (registered).
- done  output  1  one-cycle pulse when a burst completes (registered).

Behaviour:
- Reset:
  - One clock, reset is synchronous and active-high.
  - rst has priority over all other inputs at a rising edge.
  - Reset values: A=0, busy=0, done=0, counter=0, latched direction=right.
  - A reset in mid-burst aborts the burst; no done pulse is produced.
- Idle state (busy=0):
  - start=1 with mode=01 or 10 accepts a burst. This takes priority over en.
  - start=1 with mode=00 or 11 is ignored; the edge is treated as a normal single-step edge.
  - Otherwise, if en=1, one operation executes at the edge:
    - 00: A unchanged.
    - 01: A <= {sir, A[WIDTH-1:1]}.
    - 10: A <= {A[WIDTH-2:0], sil}.
    - 11: A <= I.
  - en=0: A holds.
  - Single-step latency is one edge.
- Burst acceptance edge:
  - Latch direction from mode; counter <= amt; A unchanged.
  - If amt != 0: busy <= 1, done <= 0.
  - If amt == 0: busy stays 0 and done <= 1 for one cycle; no shift occurs.
- Busy state, at each edge:
  - One shift in the latched direction, sampling sir/sil at that edge.
  - counter <= counter-1.
  - On the edge where counter==1: busy <= 0, done <= 1.
  - done drops at the following edge unless another amt=0 burst is accepted.
  - en, mode, I, start and amt are ignored while busy=1.
- Burst timing:
  - A burst of n>0 occupies n+1 edges: 1 accept edge plus n shift edges.
  - busy is high for n cycles; done is high in the cycle after the last shift.
  - A new start may be accepted in the same cycle in which done=1.
- Boundaries:
  - amt > WIDTH is legal; shifting continues and A fills entirely with serial input.
  - Maximum amt = 2^CNT_W - 1.
- Output timing: so_r and so_l follow A with no additional register stage.

Optional Feature:
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit).
  - When rot=1 at any shift edge (single-step or burst), the bit shifted out re-enters the opposite end:
    - right shift: A <= {A[0], A[WIDTH-1:1]}.
    - left shift: A <= {A[WIDTH-2:0], A[WIDTH-1]}.
  - sir/sil are ignored while rot=1.
  - rot is sampled every edge, including during a burst.
- Undefined:
  - No rot port.
  - All shifts use sir/sil exactly as in Behaviour.

Test Plan:
- WIDTH=8. rst=1 for 2 edges with I=8'hFF, mode=11, en=1 -> A=8'h00, busy=0, done=0. Then rst=0 with the same inputs -> A=8'hFF after 1 edge.
- A=8'hB4, en=1, mode=01, sir=1 -> A=8'hDA and so_r=0. Then mode=10, sil=0 -> A=8'hB4. Then en=0 for 3 edges -> A stays 8'hB4.
- A=8'h81, start=1, mode=10, amt=3, sil=1 -> busy=1 for exactly 3 cycles, A=8'h0F after the third shift edge, done=1 for exactly 1 cycle. mode=11/I=8'h00 applied while busy has no effect.
- Burst with start=1, mode=01, amt=0 -> A unchanged, busy never asserts, done pulses 1 cycle. Then start=1, mode=11 -> A <= I, no burst.
- Burst right with amt=10 and sir=0 from A=8'hFF -> A=8'h00 at completion. A second burst started during the done cycle is accepted. rst asserted on its second shift edge -> A=0, busy=0, done stays 0.
- Run with UNIV_SHIFT_ROTATE_EN defined: A=8'h81, rot=1, mode=01, en=1 -> A=8'hC0. Then a burst left with amt=8 and rot=1 -> A returns to 8'hC0 and done pulses.
